apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 1, APB address width.
  DATA_W, 32, APB data width.
  TIMEOUT, 15, max ACCESS cycles without PREADY before abort (1..255).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  apb_PCLK  in  1  clock.
  apb_PRESETn  in  1  reset.
  rN_req  in  1  requester N transaction request, N in {0,1}; held until rN_done.
  rN_write  in  1  1 = write, 0 = read.
  rN_addr  in  ADDR_W  target register address.
  rN_wdata  in  DATA_W  write data.
  rN_done  out  1  one-cycle completion pulse.
  rN_rdata  out  DATA_W  read data, valid while rN_done=1.
  rN_err  out  1  timeout flag, valid while rN_done=1.
  apb_PSEL1  out  1  APB select.
  apb_PENABLE  out  1  APB enable.
  apb_PWRITE  out  1  APB direction.
  apb_PADDR  out  ADDR_W  APB address.
  apb_PWDATA  out  DATA_W  APB write data.
  apb_PSTRB  out  4  constant 4'hF.
  apb_PPROT  out  1  constant 0.
  apb_PRDATA  in  DATA_W  APB read data.
  apb_PREADY  in  1  APB ready.
  apb_PSLVERR  in  1  ignored; the register file leaves it undriven.
REQ-003 The block SHALL use one clock, apb_PCLK; reset apb_PRESETn SHALL be synchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-005 IDLE with no eligible request: all APB outputs except the PSTRB/PPROT constants = 0.
REQ-006 IDLE with an eligible request:
  - grant one requester;
  - latch its write, addr and wdata;
  - next state = SETUP.
REQ-007 Eligibility: rN_req=1 and rN_done=0 in the same cycle, so a held req cannot retrigger on its done cycle.
REQ-008 Arbitration SHALL be round-robin, using a 1-bit pointer.
  - Both eligible: grant the requester the pointer names.
  - Pointer SHALL flip to the other requester after every completion, including timeout.
  - Pointer reset value = r0.
REQ-009 SETUP: PSEL1=1, PENABLE=0; PADDR, PWRITE and PWDATA driven from the latched values; next state = ACCESS unconditionally.
REQ-010 ACCESS: PSEL1=1, PENABLE=1, same latched values.
  - PREADY=1: next state = IDLE.
  - Otherwise increment the 8-bit wait counter; counter cleared on entry to SETUP.
REQ-011 Timeout: counter == TIMEOUT with PREADY=0 in ACCESS → next state = IDLE, abort flagged.
REQ-012 Completion outputs SHALL be registered, asserted in the cycle after the final ACCESS cycle, for exactly 1 cycle.
  - Only the granted requester's rN_done is asserted.
  - rN_rdata = PRDATA sampled on the PREADY cycle for reads; 0 for writes and for timeouts.
  - rN_err = 1 only on timeout.
REQ-013 Latency with zero-wait slave: req seen in IDLE at cycle T → SETUP at T+1, ACCESS at T+2, rN_done at T+3.
REQ-014 Requester inputs changing after grant SHALL NOT affect the transaction in flight.
REQ-015 The ungranted requester's req SHALL remain pending and be served next, with no loss.
REQ-016 rN_rdata and rN_err outside the done cycle = 0.

Reset
REQ-017 apb_PRESETn=0 at any clock edge, including mid-transaction, SHALL on the next cycle force:
  - state = IDLE;
  - pointer = r0, wait counter = 0;
  - all outputs except the PSTRB/PPROT constants = 0;
  - the aborted transaction gets no rN_done.
REQ-018 The first grant SHALL be possible in the first cycle with apb_PRESETn=1.

Structure
REQ-019 Package apb_arb_pkg SHALL hold:
  - the state enum (IDLE/SETUP/ACCESS);
  - default ADDR_W, DATA_W and TIMEOUT constants;
  - the wait-counter width (8).
REQ-020 One sub-module, apb_arb_rr2, SHALL implement the combinational two-way round-robin pick: inputs eligible[1:0] and pointer; outputs grant-valid and grant-index.
REQ-021 Target size is 120-400 lines of RTL in total.

Verification
REQ-022 r0 writes 0xDEADBEEF to addr 0 with a zero-wait slave → PSEL1 at T+1, PENABLE at T+2, r0_done=1 at T+3 with r0_err=0, and register 0 reads back 0xDEADBEEF.
REQ-023 r0 and r1 assert req in the same cycle after reset → r0 served first, r1 second, no idle gap beyond 1 IDLE cycle; repeat → r0 first again.
REQ-024 r1 reads addr 1 after that register is written with 0x12345678 → r1_done with r1_rdata=0x12345678; r0_rdata=0.
REQ-025 Slave holds PREADY=0, TIMEOUT=15 → 16 ACCESS cycles, then r0_done=1, r0_err=1, r0_rdata=0; the next grant goes to r1.
REQ-026 apb_PRESETn=0 during ACCESS → next cycle PSEL1=0, PENABLE=0, no done pulse; after release, pending r1 req granted in its first cycle.
REQ-027 r0 holds req continuously for 3 transactions → exactly 3 done pulses, each transaction 4 cycles apart.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB arbiter.
package apb_arb_pkg;

    localparam int ADDR_W_DEF  = 1;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/apb_arb_rr2.sv
// Two-way round-robin pick: the pointer breaks ties when both are eligible.
module apb_arb_rr2 (
    input  logic [1:0] eligible_i,
    input  logic       ptr_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_vld_o = |eligible_i;
        gnt_idx_o = 1'b0;
        unique case (eligible_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ptr_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two requesters share one APB master port; round-robin grant and
// an ACCESS wait-state timeout that aborts a stuck slave transfer.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              apb_PCLK,
    input  logic              apb_PRESETn,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              apb_PSEL1,
    output logic              apb_PENABLE,
    output logic              apb_PWRITE,
    output logic [ADDR_W-1:0] apb_PADDR,
    output logic [DATA_W-1:0] apb_PWDATA,
    output logic [3:0]        apb_PSTRB,
    output logic              apb_PPROT,
    input  logic [DATA_W-1:0] apb_PRDATA,
    input  logic              apb_PREADY,
    input  logic              apb_PSLVERR
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              own_q, own_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        eligible;
    logic              gnt_vld;
    logic              gnt_idx;
    logic              unused_slverr;

    // A held req must not retrigger in the cycle its done pulse is visible.
    assign eligible = {r1_req & ~done_q[1], r0_req & ~done_q[0]};

    apb_arb_rr2 u_rr2 (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_idx_o  (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    own_d   = gnt_idx;
                    write_d = gnt_idx ? r1_write : r0_write;
                    addr_d  = gnt_idx ? r1_addr  : r0_addr;
                    wdata_d = gnt_idx ? r1_wdata : r0_wdata;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb_PREADY) begin
                    state_d        = IDLE;
                    done_d[own_q]  = 1'b1;
                    rdata_d        = write_q ? '0 : apb_PRDATA;
                    ptr_d          = ~ptr_q;
                end else if (cnt_q == TO_CNT) begin
                    state_d        = IDLE;
                    done_d[own_q]  = 1'b1;
                    err_d          = 1'b1;
                    ptr_d          = ~ptr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_PCLK) begin
        if (!apb_PRESETn) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            own_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latched fields stay stale in IDLE, so the bus is gated by PSEL.
    assign apb_PSEL1   = (state_q != IDLE);
    assign apb_PENABLE = (state_q == ACCESS);
    assign apb_PWRITE  = apb_PSEL1 & write_q;
    assign apb_PADDR   = apb_PSEL1 ? addr_q  : '0;
    assign apb_PWDATA  = apb_PSEL1 ? wdata_q : '0;
    assign apb_PSTRB   = 4'hF;
    assign apb_PPROT   = 1'b0;

    assign r0_done  = done_q[0];
    assign r1_done  = done_q[1];
    assign r0_rdata = done_q[0] ? rdata_q : '0;
    assign r1_rdata = done_q[1] ? rdata_q : '0;
    assign r0_err   = done_q[0] & err_q;
    assign r1_err   = done_q[1] & err_q;

    assign unused_slverr = apb_PSLVERR;

endmodule
